// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared definitions for the HH:MM:SS clock sequencer.
//   MODE_W  - width of the mode_o state report
//   state_t - mode FSM encoding (RUN=0, SET_HR=1, SET_MIN=2; value 3 is unused and recovers to RUN)
package clock_ctrl_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2
   } state_t;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronises a raw push-button, debounces it and emits a
// one-cycle event on each accepted press.
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   btn_i    raw asynchronous button level, active-high
//   event_o  one-cycle pulse on the rising edge of the debounced level
// Parameter DEBOUNCE_CYCLES: consecutive stable synced samples that must
// differ from the current level before the level is accepted.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 200
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic event_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             level_d_q;
   logic             event_q;

   // Two-flop synchroniser, stability counter, level register and edge detector.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q1   <= 1'b0;
         sync_q2   <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         level_d_q <= 1'b0;
         event_q   <= 1'b0;
      end else begin
         sync_q1 <= btn_i;
         sync_q2 <= sync_q1;
         // Any sample agreeing with the current level restarts the count.
         if (sync_q2 != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level_q <= sync_q2;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
         level_d_q <= level_q;
         event_q   <= level_q & ~level_d_q;
      end
   end

   assign event_o = event_q;

endmodule

// File: rtl/clock_time_controller.sv
// clock_time_controller: sequencer for the HH:MM:SS bcd_counter chain.
// Divides clk_i to a 1 Hz tick, issues increment strobes with carry ripple,
// and runs the RUN -> SET_HR -> SET_MIN mode FSM from two push-buttons.
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   mode_btn_i  raw mode button (async, active-high)
//   adv_btn_i   raw advance button (async, active-high)
//   sec_ovf_i   seconds counter overflow (valid in its increment cycle)
//   min_ovf_i   minutes counter overflow
//   sec_inc_o   seconds increment strobe (combinational)
//   min_inc_o   minutes increment strobe (combinational)
//   hr_inc_o    hours increment strobe (combinational)
//   sec_clr_o   one-cycle seconds clear on leaving SET_MIN (registered)
//   mode_o      current FSM state (registered)
//   hr_blank_o  blank hour digits while setting hours (registered)
//   min_blank_o blank minute digits while setting minutes (registered)
// Build option: define CLOCK_CTRL_BLINK_EN to build the blink outputs;
// otherwise both blank outputs are tied low.
module clock_time_controller
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 10000,
   parameter int unsigned DEBOUNCE_CYCLES = 200
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mode_btn_i,
   input  logic              adv_btn_i,
   input  logic              sec_ovf_i,
   input  logic              min_ovf_i,
   output logic              sec_inc_o,
   output logic              min_inc_o,
   output logic              hr_inc_o,
   output logic              sec_clr_o,
   output logic [MODE_W-1:0] mode_o,
   output logic              hr_blank_o,
   output logic              min_blank_o
);

   localparam int unsigned PRE_W = $clog2(CLK_HZ);

   logic [PRE_W-1:0] pre_q;
   logic             tick;
   state_t           state_q;
   logic             sec_clr_q;
   logic             mode_evt;
   logic             adv_evt;
   logic             leave_set_min;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (mode_btn_i),
      .event_o (mode_evt)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (adv_btn_i),
      .event_o (adv_evt)
   );

   assign tick          = (pre_q == PRE_W'(CLK_HZ - 1));
   assign leave_set_min = (state_q == ST_SET_MIN) && mode_evt;

   // Free-running prescaler; re-phased on return to RUN so the first
   // second after setting the time is a full second.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_q <= '0;
      end else if (tick || leave_set_min) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   // Mode FSM; a mode event always takes priority over an advance event.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         sec_clr_q <= 1'b0;
      end else begin
         sec_clr_q <= 1'b0;
         case (state_q)
            ST_RUN:     if (mode_evt) state_q <= ST_SET_HR;
            ST_SET_HR:  if (mode_evt) state_q <= ST_SET_MIN;
            ST_SET_MIN: begin
               if (mode_evt) begin
                  state_q   <= ST_RUN;
                  sec_clr_q <= 1'b1;
               end
            end
            default:    state_q <= ST_RUN;
         endcase
      end
   end

   // Strobe mux: carries ripple in the same cycle so 23:59:59 wraps at once.
   always_comb begin
      sec_inc_o = 1'b0;
      min_inc_o = 1'b0;
      hr_inc_o  = 1'b0;
      case (state_q)
         ST_RUN: begin
            sec_inc_o = tick;
            min_inc_o = sec_ovf_i;
            hr_inc_o  = min_ovf_i;
         end
         ST_SET_HR:  hr_inc_o  = adv_evt & ~mode_evt;
         ST_SET_MIN: min_inc_o = adv_evt & ~mode_evt;
         default: ;
      endcase
   end

   assign sec_clr_o = sec_clr_q;
   assign mode_o    = state_q;

`ifdef CLOCK_CTRL_BLINK_EN
   localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);

   logic hr_blank_q;
   logic min_blank_q;

   // Blank the digits being set during the second half of each second.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hr_blank_q  <= 1'b0;
         min_blank_q <= 1'b0;
      end else begin
         hr_blank_q  <= (state_q == ST_SET_HR)  && (pre_q >= PRE_HALF);
         min_blank_q <= (state_q == ST_SET_MIN) && (pre_q >= PRE_HALF);
      end
   end

   assign hr_blank_o  = hr_blank_q;
   assign min_blank_o = min_blank_q;
`else
   assign hr_blank_o  = 1'b0;
   assign min_blank_o = 1'b0;
`endif

endmodule
